// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider controller for
// DIV/DIVU/REM/REMU. One quotient bit is produced per clock in CALC, and
// sign correction plus the RISC-V special-case override are applied in FIX.
// The result is registered into result_o on entry to DONE.
//
// Optional feature macro: DIV_SPECIAL_FASTPATH_EN
//   defined   - divide-by-zero and signed overflow finish in 1 cycle
//   undefined - every operation takes the full XLEN+2 cycles; the override
//               is applied in FIX, so results are identical.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN-1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which reads correctly as an unsigned magnitude.
  function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v);
    f_abs = v[XLEN-1] ? (ZERO - v) : v;
  endfunction

  // Conditional negation used for sign correction.
  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic en);
    f_cneg = en ? (ZERO - v) : v;
  endfunction

  // RISC-V architectural results for divide-by-zero and signed overflow.
  function automatic logic [XLEN-1:0] f_override(
    input logic            is_rem,
    input logic            div0,
    input logic            ovf,
    input logic [XLEN-1:0] dividend,
    input logic [XLEN-1:0] normal
  );
    if (div0) begin
      f_override = is_rem ? dividend : ALL_ONES;
    end else if (ovf) begin
      f_override = is_rem ? ZERO : MIN_NEG;
    end else begin
      f_override = normal;
    end
  endfunction

  state_t            r_state;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_rs1;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_op_rem;
  logic              r_div0;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // Start-cycle operand preparation.
  logic              w_signed;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg_q;
  logic              w_neg_r;
  logic              w_div0;
  logic              w_ovf;

  assign w_signed = ~op_i[0];
  assign w_a_mag  = w_signed ? f_abs(rs1_i) : rs1_i;
  assign w_b_mag  = w_signed ? f_abs(rs2_i) : rs2_i;
  assign w_neg_q  = w_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
  assign w_neg_r  = w_signed & rs1_i[XLEN-1];
  assign w_div0   = (rs2_i == ZERO);
  assign w_ovf    = w_signed & (rs1_i == MIN_NEG) & (rs2_i == ALL_ONES);

  // One restoring step: shift in the next dividend bit, trial-subtract in
  // XLEN+1 bits; the top bit of the difference is the borrow.
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  // Sign correction, quotient/remainder select and override for FIX.
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_sel_fix;
  logic [XLEN-1:0]   w_fix_res;

  assign w_q_fix   = f_cneg(r_quo, r_neg_q);
  assign w_r_fix   = f_cneg(r_rem, r_neg_r);
  assign w_sel_fix = r_op_rem ? w_r_fix : w_q_fix;
  assign w_fix_res = f_override(r_op_rem, r_div0, r_ovf, r_rs1, w_sel_fix);

`ifdef DIV_SPECIAL_FASTPATH_EN
  logic              w_fast_hit;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_hit = w_div0 | w_ovf;
  assign w_fast_res = f_override(op_i[1], w_div0, w_ovf, rs1_i, ZERO);
`endif

  // Sequencer FSM with registered busy/done/result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_rem    <= ZERO;
      r_quo    <= ZERO;
      r_dvs    <= ZERO;
      r_rs1    <= ZERO;
      r_cnt    <= CNT_ZERO;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_op_rem <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ZERO;
    end else if (kill_i) begin
      // Flush wins over everything, including a simultaneous start.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= ZERO;
            r_rs1    <= rs1_i;
            r_cnt    <= CNT_LOAD;
            r_neg_q  <= w_neg_q;
            r_neg_r  <= w_neg_r;
            r_op_rem <= op_i[1];
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
`ifdef DIV_SPECIAL_FASTPATH_EN
            if (w_fast_hit) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state  <= S_CALC;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
            end
`else
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == CNT_ZERO) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (XLEN=32).
module tb_div_sequencer;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i  = 1'b0;
  logic [1:0]  op_i    = 2'b00;
  logic [31:0] rs1_i   = 32'h0;
  logic [31:0] rs2_i   = 32'h0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int LAT_FULL  = 34;
  localparam int BUSY_FULL = 33;
`ifdef DIV_SPECIAL_FASTPATH_EN
  localparam int LAT_SPECIAL  = 1;
  localparam int BUSY_SPECIAL = 0;
`else
  localparam int LAT_SPECIAL  = 34;
  localparam int BUSY_SPECIAL = 33;
`endif

  div_sequencer #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n cycles, ending 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Issue one operation from a mid-cycle point and wait (bounded) for done_o.
  // lat counts the start cycle as edge 1; busy_cnt counts cycles with busy_o.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic [31:0] res);
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (done_o !== 1'b1 && lat < 100) begin
      if (busy_o === 1'b1) busy_cnt++;
      @(posedge clk_i);
      #1;
      lat++;
    end
    res = result_o;
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #2;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_signed();
    int lat; int bc; logic [31:0] res;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc, res);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffd", res); end
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL div_m7_2_latency: got %0d expected %0d", lat, LAT_FULL); end
    idle(1);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_strobe: got %b expected 0", done_o); end
    checks++; if (result_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL result_hold: got %h expected fffffffd", result_o); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc, res);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h expected ffffffff", res); end
    idle(1);
    run_op(OP_DIV, 32'h0000_0014, 32'hFFFF_FFFA, lat, bc, res);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_20_m6: got %h expected fffffffd", res); end
    idle(1);
    run_op(OP_REM, 32'h0000_0014, 32'hFFFF_FFFA, lat, bc, res);
    checks++; if (res !== 32'h0000_0002) begin errors++; $display("FAIL rem_20_m6: got %h expected 00000002", res); end
    idle(1);
  endtask

  task automatic test_unsigned();
    int lat; int bc; logic [31:0] res;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, lat, bc, res);
    checks++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_ffffffff_16: got %h expected 0fffffff", res); end
    checks++; if (bc !== BUSY_FULL) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected %0d", bc, BUSY_FULL); end
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL divu_latency: got %0d expected %0d", lat, LAT_FULL); end
    idle(1);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, lat, bc, res);
    checks++; if (res !== 32'h0000_000F) begin errors++; $display("FAIL remu_ffffffff_16: got %h expected 0000000f", res); end
    idle(1);
  endtask

  task automatic test_special();
    int lat; int bc; logic [31:0] res;
    logic [1:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] av  [6] = '{32'h8000_0000, 32'h8000_0000, 32'h5, 32'h5, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bv  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ev  [6] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], av[i], bv[i], lat, bc, res);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL special_%0d_result: got %h expected %h", i, res, ev[i]); end
      checks++; if (lat !== LAT_SPECIAL) begin errors++; $display("FAIL special_%0d_latency: got %0d expected %0d", i, lat, LAT_SPECIAL); end
      checks++; if (bc !== BUSY_SPECIAL) begin errors++; $display("FAIL special_%0d_busy: got %0d expected %0d", i, bc, BUSY_SPECIAL); end
      idle(1);
    end
  endtask

  task automatic test_kill();
    int lat; int bc; int done_seen; logic [31:0] res;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL kill_pre_divu: got %h expected 0000000e", res); end
    idle(1);
    op_i = OP_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
    idle(1);
    start_i = 1'b0;
    idle(9);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %b expected 1", busy_o); end
    kill_i = 1'b1;
    idle(1);
    kill_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_busy_after: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL kill_done_after: got %b expected 0", done_o); end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) done_seen++;
      idle(1);
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL kill_no_done: got %0d strobes expected 0", done_seen); end
    checks++; if (result_o !== 32'd14) begin errors++; $display("FAIL kill_result_held: got %h expected 0000000e", result_o); end
    // kill and start in the same cycle: kill must win
    op_i = OP_DIVU; rs1_i = 32'd9; rs2_i = 32'd3; start_i = 1'b1; kill_i = 1'b1;
    idle(1);
    start_i = 1'b0; kill_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_beats_start: got busy %b expected 0", busy_o); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL kill_post_divu: got %h expected 0000000e", res); end
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL kill_post_latency: got %0d expected %0d", lat, LAT_FULL); end
  endtask

  task automatic test_back_to_back();
    int lat; int bc; logic [31:0] res;
    idle(1);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL b2b_first: got %h expected 0000000e", res); end
    // Issued in the DONE cycle of the previous operation.
    run_op(OP_REMU, 32'd100, 32'd7, lat, bc, res);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL b2b_second: got %h expected 00000002", res); end
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++; if (bc !== BUSY_FULL) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", bc, BUSY_FULL); end
  endtask

  task automatic test_async_reset();
    int lat; int bc; logic [31:0] res;
    idle(1);
    op_i = OP_DIV; rs1_i = 32'hFFFF_FFF9; rs2_i = 32'h2; start_i = 1'b1;
    idle(1);
    start_i = 1'b0;
    idle(5);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b expected 1", busy_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", done_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL arst_result: got %h expected 00000000", result_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(3);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_idle_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL arst_idle_done: got %b expected 0", done_o); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, res);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL arst_post_divu: got %h expected 0000000e", res); end
    checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL arst_post_latency: got %0d expected %0d", lat, LAT_FULL); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
